// File: rtl/tstamp_pkg.sv
// -----------------------------------------------------------------------------
// tstamp_pkg
// Shared definitions for the timestamp scheduler:
//   NCH_DEF / TW_DEF : default channel count and timestamp width
//   EPOCH_W          : width of the optional epoch counter (TSTAMP_EPOCH_EN)
//   state_e          : run-control states IDLE / RUN / HALT
//   fsm_next()       : run-control next state, clear > stop > start
// -----------------------------------------------------------------------------
package tstamp_pkg;

   localparam int NCH_DEF = 4;
   localparam int TW_DEF  = 16;
   localparam int EPOCH_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // stop only has an effect in RUN; when stop is high, start is ignored
   // even in states where stop itself does nothing.
   function automatic state_e fsm_next(state_e cur, logic start, logic stop,
                                       logic clear);
      state_e nxt;
      nxt = cur;
      if (clear) begin
         nxt = ST_IDLE;
      end else if (stop) begin
         if (cur == ST_RUN) nxt = ST_HALT;
      end else if (start) begin
         nxt = ST_RUN;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/tstamp_scheduler_if.sv
// -----------------------------------------------------------------------------
// tstamp_scheduler_if
// Record output channel of the timestamp scheduler.
//   rec_valid : record available (producer)
//   rec_ready : consumer accepts record
//   rec_ch    : channel of the record
//   rec_stamp : captured count
//   rec_epoch : captured epoch (only with TSTAMP_EPOCH_EN)
// Handshake: a record transfers on a rising edge where rec_valid && rec_ready;
// while rec_valid && !rec_ready the producer holds rec_valid, rec_ch,
// rec_stamp (and rec_epoch) stable; rec_ready may change freely.
// master = scheduler side, slave = consumer side.
// -----------------------------------------------------------------------------
interface tstamp_scheduler_if #(
   parameter int NCH = tstamp_pkg::NCH_DEF,
   parameter int TW  = tstamp_pkg::TW_DEF
);
   localparam int CW = $clog2(NCH);

   logic          rec_valid;
   logic          rec_ready;
   logic [CW-1:0] rec_ch;
   logic [TW-1:0] rec_stamp;
`ifdef TSTAMP_EPOCH_EN
   logic [tstamp_pkg::EPOCH_W-1:0] rec_epoch;

   modport master (output rec_valid, rec_ch, rec_stamp, rec_epoch,
                   input  rec_ready);
   modport slave  (input  rec_valid, rec_ch, rec_stamp, rec_epoch,
                   output rec_ready);
`else
   modport master (output rec_valid, rec_ch, rec_stamp,
                   input  rec_ready);
   modport slave  (input  rec_valid, rec_ch, rec_stamp,
                   output rec_ready);
`endif

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin selection of one requester per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : N request bits
//   en_i          : a grant may be taken this cycle
//   gnt_o         : one-hot grant (zero when en_i low or no request)
//   gnt_idx_o     : index of the selected requester
//   gnt_any_o     : a grant is issued this cycle
// The search starts at the pointer, which moves to last grant + 1 only when a
// grant is actually issued; it is 0 after reset.
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N-1:0]         req_i,
   input  logic                 en_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] gnt_idx_o,
   output logic                 gnt_any_o
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx;
   logic [IW-1:0] cand_idx;
   logic          found;
   int            cand;

   always_comb begin
      found    = 1'b0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand     = (int'(ptr_q) + k) % N;
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
      gnt_any_o = found && en_i;
      gnt_idx_o = idx;
      gnt_o     = gnt_any_o ? (N'(1) << idx) : '0;
      ptr_d     = ptr_q;
      if (gnt_any_o) ptr_d = (int'(idx) == N - 1) ? '0 : idx + IW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/tstamp_scheduler.sv
// -----------------------------------------------------------------------------
// tstamp_scheduler
// Free-running timestamp counter with per-channel event capture. Each channel
// holds at most one pending stamp; pending channels are drained round-robin,
// one per cycle, into a single registered record output.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   start/stop   : run/resume and freeze the counter (stop wins over start)
//   clear        : back to IDLE, zero count, flush pending and record
//   ev_req       : per-channel single-cycle event strobes (used in RUN only)
//   ev_drop      : per-channel pulse, event lost because its stamp was busy
//   busy         : high while in RUN
//   wrap         : one-cycle pulse in the cycle the count reads 0 after rollover
//   dbg_state_o  : current run-control state
//   rec          : record channel (rec_valid/rec_ready/rec_ch/rec_stamp)
// Optional feature macro TSTAMP_EPOCH_EN: 8-bit epoch counter advanced on each
// wrap, captured with every event and presented as rec.rec_epoch.
// Event-to-rec_valid latency is 2 cycles: capture edge, then grant/load edge.
// -----------------------------------------------------------------------------
module tstamp_scheduler
   import tstamp_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int TW  = TW_DEF
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               start,
   input  logic               stop,
   input  logic               clear,
   input  logic [NCH-1:0]     ev_req,
   output logic [NCH-1:0]     ev_drop,
   output logic               busy,
   output logic               wrap,
   output state_e             dbg_state_o,
   tstamp_scheduler_if.master rec
);
   localparam int CW = $clog2(NCH);

   state_e         state_q, state_d;
   logic [TW-1:0]  count_q, count_d;
   logic [NCH-1:0] pend_q, pend_d;
   logic [TW-1:0]  pstamp_q [NCH];
   logic [TW-1:0]  pstamp_d [NCH];
   logic [NCH-1:0] drop_q, drop_d;
   logic           wrap_q, wrap_d;
   logic           busy_q, busy_d;
   logic           valid_q, valid_d;
   logic [CW-1:0]  ch_q, ch_d;
   logic [TW-1:0]  stamp_q, stamp_d;
`ifdef TSTAMP_EPOCH_EN
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [EPOCH_W-1:0] rep_q, rep_d;
   logic [EPOCH_W-1:0] pepoch_q [NCH];
   logic [EPOCH_W-1:0] pepoch_d [NCH];
`endif

   logic           load_ok;
   logic           arb_en;
   logic [NCH-1:0] gnt;
   logic [CW-1:0]  gnt_idx;
   logic           gnt_any;

   // Output register can take a new record when empty or being emptied.
   assign load_ok = !valid_q || rec.rec_ready;
   // Nothing is granted during clear so the round-robin pointer is kept.
   assign arb_en  = load_ok && !clear;

   rr_arbiter #(.N(NCH)) u_arb (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .req_i     (pend_q),
      .en_i      (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   // Run control and counter
   always_comb begin
      state_d = fsm_next(state_q, start, stop, clear);
      busy_d  = (state_d == ST_RUN);
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (state_q == ST_RUN) begin
         count_d = count_q + TW'(1);
         wrap_d  = &count_q;
      end
`ifdef TSTAMP_EPOCH_EN
      epoch_d = clear ? '0 : (wrap_d ? epoch_q + EPOCH_W'(1) : epoch_q);
`endif
   end

   // Event capture. The granted bit is released first, so an event on the
   // channel being granted this cycle is captured rather than dropped.
   always_comb begin
      pend_d   = pend_q & ~gnt;
      pstamp_d = pstamp_q;
      drop_d   = '0;
`ifdef TSTAMP_EPOCH_EN
      pepoch_d = pepoch_q;
`endif
      if (clear) begin
         pend_d = '0;
      end else if (state_q == ST_RUN) begin
         for (int i = 0; i < NCH; i++) begin
            if (ev_req[i]) begin
               if (pend_d[i]) begin
                  drop_d[i] = 1'b1;
               end else begin
                  pend_d[i]   = 1'b1;
                  pstamp_d[i] = count_q;
`ifdef TSTAMP_EPOCH_EN
                  pepoch_d[i] = epoch_q;
`endif
               end
            end
         end
      end
   end

   // Record register
   always_comb begin
      valid_d = valid_q;
      ch_d    = ch_q;
      stamp_d = stamp_q;
`ifdef TSTAMP_EPOCH_EN
      rep_d   = rep_q;
`endif
      if (clear) begin
         valid_d = 1'b0;
      end else if (load_ok) begin
         valid_d = gnt_any;
         if (gnt_any) begin
            ch_d    = gnt_idx;
            stamp_d = pstamp_q[gnt_idx];
`ifdef TSTAMP_EPOCH_EN
            rep_d   = pepoch_q[gnt_idx];
`endif
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         pend_q  <= '0;
         for (int i = 0; i < NCH; i++) pstamp_q[i] <= '0;
         drop_q  <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         stamp_q <= '0;
`ifdef TSTAMP_EPOCH_EN
         epoch_q <= '0;
         rep_q   <= '0;
         for (int i = 0; i < NCH; i++) pepoch_q[i] <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         pstamp_q <= pstamp_d;
         drop_q   <= drop_d;
         wrap_q   <= wrap_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         ch_q     <= ch_d;
         stamp_q  <= stamp_d;
`ifdef TSTAMP_EPOCH_EN
         epoch_q  <= epoch_d;
         rep_q    <= rep_d;
         pepoch_q <= pepoch_d;
`endif
      end
   end

   assign ev_drop       = drop_q;
   assign busy          = busy_q;
   assign wrap          = wrap_q;
   assign dbg_state_o   = state_q;
   assign rec.rec_valid = valid_q;
   assign rec.rec_ch    = ch_q;
   assign rec.rec_stamp = stamp_q;
`ifdef TSTAMP_EPOCH_EN
   assign rec.rec_epoch = rep_q;
`endif

endmodule

// File: tb/tb_tstamp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tstamp_scheduler
// Testbench for tstamp_scheduler (default NCH=4, TW=16). Directed scenarios
// followed by randomized control/event/ready traffic, all compared each cycle
// against a behavioural model; delivered records are also matched against an
// expected-record queue. Honours TSTAMP_EPOCH_EN when defined.
// -----------------------------------------------------------------------------
module tb_tstamp_scheduler;
   import tstamp_pkg::*;

   localparam int NCH  = 4;
   localparam int TW   = 16;
   localparam int W    = 16 + TW;
   localparam int MAXC = (1 << TW) - 1;

   // ---------------- clock / reset ----------------
   logic           CLK   = 1'b0;
   logic           RST_N = 1'b1;
   logic           start = 1'b0;
   logic           stop  = 1'b0;
   logic           clear = 1'b0;
   logic [NCH-1:0] ev_req = '0;
   logic [NCH-1:0] ev_drop;
   logic           busy;
   logic           wrap;
   state_e         dbg_state;

   always #5 CLK = ~CLK;

   tstamp_scheduler_if #(.NCH(NCH), .TW(TW)) rec_if ();

   tstamp_scheduler #(.NCH(NCH), .TW(TW)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .ev_req      (ev_req),
      .ev_drop     (ev_drop),
      .busy        (busy),
      .wrap        (wrap),
      .dbg_state_o (dbg_state),
      .rec         (rec_if)
   );

   // ---------------- reference model state ----------------
   state_e         m_state;
   int             m_count, m_ptr, m_epoch, m_ch, m_stamp, m_rep;
   bit             m_val, m_wrap;
   bit [NCH-1:0]   m_pend, m_drop;
   int             m_pst [NCH];
   int             m_pep [NCH];
   logic [W-1:0]   exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pack_rec(int ch, int ep, int st);
      logic [7:0]    c8;
      logic [7:0]    e8;
      logic [TW-1:0] s;
      c8 = 8'(ch);
      e8 = 8'(ep);
      s  = TW'(st);
      return {c8, e8, s};
   endfunction

   function automatic int dut_ep();
`ifdef TSTAMP_EPOCH_EN
      return int'(rec_if.rec_epoch);
`else
      return 0;
`endif
   endfunction

   function automatic int model_ep(int e);
`ifdef TSTAMP_EPOCH_EN
      return e;
`else
      return e & 0;
`endif
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE;
      m_count = 0; m_ptr = 0; m_epoch = 0;
      m_ch = 0; m_stamp = 0; m_rep = 0;
      m_val = 0; m_wrap = 0; m_pend = '0; m_drop = '0;
      for (int i = 0; i < NCH; i++) begin
         m_pst[i] = 0;
         m_pep[i] = 0;
      end
      exp_q.delete();
   endtask

   // One rising edge of the specified behaviour with the current inputs.
   task automatic model_step();
      bit load;
      int g;
      int c;
      load = !m_val || rec_if.rec_ready;
      g = -1;
      if (load && !clear) begin
         for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (g < 0 && m_pend[c]) g = c;
         end
      end
      m_drop = '0;
      m_wrap = 0;
      if (clear) begin
         m_state = ST_IDLE;
         m_count = 0;
         m_epoch = 0;
         m_pend  = '0;
         m_val   = 0;
         exp_q.delete();
      end else begin
         if (g >= 0) begin
            m_val   = 1;
            m_ch    = g;
            m_stamp = m_pst[g];
            m_rep   = m_pep[g];
            m_pend[g] = 0;
            m_ptr   = (g + 1) % NCH;
            exp_q.push_back(pack_rec(g, model_ep(m_rep), m_stamp));
         end else if (load) begin
            m_val = 0;
         end
         if (m_state == ST_RUN) begin
            for (int i = 0; i < NCH; i++) begin
               if (ev_req[i]) begin
                  if (m_pend[i]) m_drop[i] = 1;
                  else begin
                     m_pend[i] = 1;
                     m_pst[i]  = m_count;
                     m_pep[i]  = m_epoch;
                  end
               end
            end
            if (m_count == MAXC) begin
               m_count = 0;
               m_wrap  = 1;
               m_epoch = (m_epoch + 1) % 256;
            end else begin
               m_count = m_count + 1;
            end
         end
         if (stop) begin
            if (m_state == ST_RUN) m_state = ST_HALT;
         end else if (start) begin
            m_state = ST_RUN;
         end
      end
   endtask

   task automatic compare_outputs();
      check("rec_valid", rec_if.rec_valid, m_val);
      if (m_val) begin
         check("rec_ch", rec_if.rec_ch, m_ch);
         check("rec_stamp", rec_if.rec_stamp, m_stamp);
`ifdef TSTAMP_EPOCH_EN
         check("rec_epoch", rec_if.rec_epoch, m_rep);
`endif
      end
      check("ev_drop", ev_drop, m_drop);
      check("wrap", wrap, m_wrap);
      check("busy", busy, m_state == ST_RUN);
      check("state", dbg_state, m_state);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      logic [W-1:0] e;
      if (rec_if.rec_valid === 1'b1 && rec_if.rec_ready && !clear) begin
         check("sb_depth", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_record",
                  pack_rec(int'(rec_if.rec_ch), dut_ep(), int'(rec_if.rec_stamp)), e);
         end
      end
      @(posedge CLK);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      start = 0; stop = 0; clear = 0; ev_req = '0;
      rec_if.rec_ready = 1'b0;
      #1;
      model_reset();
      check("rst_valid", rec_if.rec_valid, 0);
      check("rst_ch", rec_if.rec_ch, 0);
      check("rst_stamp", rec_if.rec_stamp, 0);
      check("rst_drop", ev_drop, 0);
      check("rst_wrap", wrap, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, ST_IDLE);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to(input int c);
      int budget;
      budget = 70000;
      while (m_count != c && budget > 0) begin
         tick();
         budget--;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #3;
      do_reset();

      // single event at count 5, 2-cycle latency
      start_run();
      run_to(5);
      ev_req = 4'b0001; tick(); ev_req = '0;
      check("s1_lat1_valid", rec_if.rec_valid, 0);
      tick();
      check("s1_valid", rec_if.rec_valid, 1);
      check("s1_ch", rec_if.rec_ch, 0);
      check("s1_stamp", rec_if.rec_stamp, 5);
      rec_if.rec_ready = 1'b1; tick();

      // all channels at count 10, drained on consecutive cycles
      do_reset();
      rec_if.rec_ready = 1'b1;
      start_run();
      run_to(10);
      ev_req = 4'b1111; tick(); ev_req = '0;
      check("s2_lat1_valid", rec_if.rec_valid, 0);
      for (int k = 0; k < NCH; k++) begin
         tick();
         check("s2_valid", rec_if.rec_valid, 1);
         check("s2_ch", rec_if.rec_ch, k);
         check("s2_stamp", rec_if.rec_stamp, 10);
      end
      tick();
      check("s2_drained", rec_if.rec_valid, 0);

      // output blocked, ch2 twice: one drop, first stamp kept
      do_reset();
      start_run();
      run_to(1);
      ev_req = 4'b0001; tick(); ev_req = '0;
      run_to(3);
      ev_req = 4'b0100; tick(); ev_req = '0;
      run_to(7);
      ev_req = 4'b0100; tick(); ev_req = '0;
      check("s3_drop", ev_drop, 4'b0100);
      tick();
      check("s3_drop_once", ev_drop, 4'b0000);
      rec_if.rec_ready = 1'b1;
      tick();
      check("s3_ch", rec_if.rec_ch, 2);
      check("s3_stamp", rec_if.rec_stamp, 3);
      repeat (3) tick();

      // rollover
      do_reset();
      rec_if.rec_ready = 1'b1;
      start_run();
      run_to(MAXC - 1);
      tick();
      check("s4_no_wrap_yet", wrap, 0);
      tick();
      check("s4_wrap", wrap, 1);
      ev_req = 4'b0001; tick(); ev_req = '0;
      check("s4_wrap_pulse_end", wrap, 0);
      tick();
      check("s4_valid", rec_if.rec_valid, 1);
      check("s4_stamp", rec_if.rec_stamp, 0);
`ifdef TSTAMP_EPOCH_EN
      check("s4_epoch", rec_if.rec_epoch, 1);
`endif
      tick();

      // halt at 20, events ignored, resume at 21
      do_reset();
      rec_if.rec_ready = 1'b1;
      start_run();
      run_to(20);
      stop = 1'b1; tick(); stop = 1'b0;
      check("s5_busy_halt", busy, 0);
      for (int k = 0; k < 3; k++) begin
         ev_req = 4'b1111; tick(); ev_req = '0;
         check("s5_halt_valid", rec_if.rec_valid, 0);
         check("s5_halt_drop", ev_drop, 0);
      end
      tick();
      check("s5_halt_valid2", rec_if.rec_valid, 0);
      start_run();
      ev_req = 4'b0001; tick(); ev_req = '0;
      tick();
      check("s5_valid", rec_if.rec_valid, 1);
      check("s5_stamp", rec_if.rec_stamp, 21);
      tick();

      // reset with record held and channels pending
      do_reset();
      start_run();
      run_to(2);
      ev_req = 4'b1111; tick(); ev_req = '0;
      tick(); tick();
      check("s6_pre_valid", rec_if.rec_valid, 1);
      do_reset();
      rec_if.rec_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("s6_no_rec", rec_if.rec_valid, 0);
      end

      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         start  = ($urandom_range(0, 9) == 0);
         stop   = ($urandom_range(0, 24) == 0);
         clear  = ($urandom_range(0, 99) == 0);
         ev_req = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
         rec_if.rec_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      start = 0; stop = 0; clear = 0; ev_req = '0;
      rec_if.rec_ready = 1'b1;
      repeat (10) tick();
      check("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      n_errors++;
      $display("FAIL watchdog: bench did not complete in time");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tstamp_scheduler.md
TSTAMP_SCHEDULER -- requirements
Module: tstamp_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of event channels (2..8).
REQ-002 SHALL have parameter TW, default 16, timestamp counter width.
REQ-003 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RST_N  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  run/resume timestamp counter.
REQ-006 SHALL have port stop  input  1  freeze counter.
REQ-007 SHALL have port clear  input  1  zero counter, flush pending and output.
REQ-008 SHALL have port ev_req  input  NCH  per-channel single-cycle event strobes.
REQ-009 SHALL have port ev_drop  output  NCH  per-channel lost-event pulse.
REQ-010 SHALL have port rec_valid  output  1  record available.
REQ-011 SHALL have port rec_ready  input  1  consumer accepts record.
REQ-012 SHALL have port rec_ch  output  clog2(NCH)  channel of record.
REQ-013 SHALL have port rec_stamp  output  TW  captured count.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse on counter rollover.

Function
REQ-016 SHALL implement states IDLE (count held 0), RUN (count +1 per cycle), HALT (count frozen).
REQ-017 SHALL transition IDLE->RUN and HALT->RUN on start; RUN->HALT on stop; any state->IDLE on clear.
REQ-018 SHALL prioritise clear over stop over start when asserted together.
REQ-019 SHALL wrap count from all-ones to 0 modulo 2^TW and pulse wrap in the cycle count reads 0 after rollover.
REQ-020 SHALL, in RUN only, on ev_req[i] set pend[i] and latch pstamp[i] = count value of that cycle; events in IDLE/HALT ignored, no drop.
REQ-021 SHALL, when ev_req[i] arrives while pend[i] set and not granted that cycle, discard the event and pulse ev_drop[i] next cycle; the held stamp is unchanged.
REQ-022 SHALL, when ev_req[i] arrives in the cycle pend[i] is granted, capture the new event (pend[i] stays set, new stamp).
REQ-023 SHALL grant one pending channel per cycle, round-robin, starting search at last grant +1 (pointer 0 after reset).
REQ-024 SHALL load the output register when rec_valid is 0 or rec_valid&&rec_ready, clearing the granted pend bit.
REQ-025 SHALL hold rec_valid, rec_ch, rec_stamp stable while rec_valid&&!rec_ready.
REQ-026 SHALL give event-to-rec_valid latency of 2 cycles minimum.
REQ-027 SHALL on clear deassert rec_valid and clear all pend bits next cycle.

Reset
REQ-028 SHALL on RST_N low asynchronously force IDLE, count 0, pend 0, pointer 0, and outputs rec_valid, ev_drop, wrap, busy, rec_ch, rec_stamp all 0.
REQ-029 SHALL, on reset mid-operation, discard all pending and held records; no ev_drop reported for them.

Configuration
REQ-030 SHALL, with TSTAMP_EPOCH_EN defined, keep an 8-bit epoch counter incremented on each wrap, cleared by clear/reset, captured per event, output on port rec_epoch (output 8).
REQ-031 SHALL, without TSTAMP_EPOCH_EN, omit epoch counter and rec_epoch port entirely.

Structure
REQ-032 SHALL place TW/NCH defaults and IDLE/RUN/HALT state encodings in package tstamp_pkg.
REQ-033 SHALL implement grant selection in sub-module rr_arbiter (NCH req in, one-hot grant out, pointer update).

Verification
REQ-034 SHALL cover: start, ev_req=0001 at count 5 -> record ch0 stamp 5, rec_valid 2 cycles after event.
REQ-035 SHALL cover: ev_req=1111 same cycle at count 10, rec_ready=1 -> records ch0,1,2,3 all stamp 10, consecutive cycles.
REQ-036 SHALL cover: rec_ready=0, ch2 fires twice (counts 3, 7) -> ev_drop[2] pulse once; later record ch2 stamp 3.
REQ-037 SHALL cover: RUN from 0xFFFE -> wrap pulse when count 0; event at that cycle stamps 0 (epoch 1 if TSTAMP_EPOCH_EN).
REQ-038 SHALL cover: stop at count 20, events during HALT -> no records, no drops; start -> count resumes at 21.
REQ-039 SHALL cover: RST_N low with pending records and rec_valid=1 -> all outputs 0 immediately, no records after release.
